alu_rs: RTL

ALU reservation station and issue scheduler for the out-of-order core. Holds up to RS_SIZE dispatched ALU/branch/jump instructions, snoops both common-data-bus broadcasts to resolve pending operands, and issues at most one operand-complete instruction per cycle to the combinational ALU through a registered issue port. Sits between the dispatcher (decoder/ROB allocation) and the ALU; the ALU's CDB output loops back into this block's wake-up port.

---
 rtl/alu_rs.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU/branch ops, wakes operands from both CDBs,
// and issues the lowest-index ready entry to the ALU through registered outputs.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif
`ifndef OP_NULL
`define OP_NULL 6'd0
`endif

module alu_rs #(
  parameter int RS_SIZE      = 16,
  parameter int ROB_SIZE_LOG = `ROB_SIZE_LOG
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rdy,
  input  logic                    i_clear,
  input  logic                    i_disp_valid,
  input  logic [5:0]              i_disp_op,
  input  logic [31:0]             i_disp_vj,
  input  logic [31:0]             i_disp_vk,
  input  logic                    i_disp_qj_busy,
  input  logic                    i_disp_qk_busy,
  input  logic [ROB_SIZE_LOG-1:0] i_disp_qj,
  input  logic [ROB_SIZE_LOG-1:0] i_disp_qk,
  input  logic [31:0]             i_disp_imm,
  input  logic [31:0]             i_disp_curpc,
  input  logic [ROB_SIZE_LOG-1:0] i_disp_robid,
  output logic                    o_rs_full,
  input  logic                    i_cdb_alu_en,
  input  logic                    i_cdb_lsb_en,
  input  logic [ROB_SIZE_LOG-1:0] i_cdb_alu_robid,
  input  logic [ROB_SIZE_LOG-1:0] i_cdb_lsb_robid,
  input  logic [31:0]             i_cdb_alu_value,
  input  logic [31:0]             i_cdb_lsb_value,
  output logic                    o_alu_valid,
  output logic [5:0]              o_alu_op,
  output logic [31:0]             o_alu_vj,
  output logic [31:0]             o_alu_vk,
  output logic [31:0]             o_alu_imm,
  output logic [31:0]             o_alu_curpc,
  output logic [ROB_SIZE_LOG-1:0] o_alu_robid
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]      r_busy;
  logic [RS_SIZE-1:0]      r_qj_busy;
  logic [RS_SIZE-1:0]      r_qk_busy;
  logic [5:0]              r_op    [RS_SIZE];
  logic [31:0]             r_vj    [RS_SIZE];
  logic [31:0]             r_vk    [RS_SIZE];
  logic [31:0]             r_imm   [RS_SIZE];
  logic [31:0]             r_curpc [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] r_qj    [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] r_qk    [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] r_robid [RS_SIZE];

  logic                    r_alu_valid;
  logic [5:0]              r_alu_op;
  logic [31:0]             r_alu_vj;
  logic [31:0]             r_alu_vk;
  logic [31:0]             r_alu_imm;
  logic [31:0]             r_alu_curpc;
  logic [ROB_SIZE_LOG-1:0] r_alu_robid;

  logic [RS_SIZE-1:0]      w_ready;
  logic                    w_sel_valid;
  logic [IDX_W-1:0]        w_sel_idx;
  logic [IDX_W-1:0]        w_free_idx;
  logic                    w_full;
  logic                    w_disp_fire;
  logic [32:0]             w_look_j [RS_SIZE];
  logic [32:0]             w_look_k [RS_SIZE];
  logic [32:0]             w_disp_look_j;
  logic [32:0]             w_disp_look_k;
  logic                    w_disp_qj_busy;
  logic                    w_disp_qk_busy;
  logic [31:0]             w_disp_vj;
  logic [31:0]             w_disp_vk;

  // {hit, value}: ALU CDB takes precedence over the LSB CDB
  function automatic logic [32:0] cdb_lookup(
    input logic [ROB_SIZE_LOG-1:0] tag,
    input logic                    a_en,
    input logic [ROB_SIZE_LOG-1:0] a_tag,
    input logic [31:0]             a_val,
    input logic                    l_en,
    input logic [ROB_SIZE_LOG-1:0] l_tag,
    input logic [31:0]             l_val
  );
    logic [32:0] res;
    if (a_en && (tag == a_tag)) begin
      res = {1'b1, a_val};
    end else if (l_en && (tag == l_tag)) begin
      res = {1'b1, l_val};
    end else begin
      res = {1'b0, 32'd0};
    end
    return res;
  endfunction

  assign w_ready     = r_busy & ~r_qj_busy & ~r_qk_busy;
  assign w_full      = &r_busy;
  assign w_sel_valid = |w_ready;
  assign w_disp_fire = i_disp_valid && !w_full && (i_disp_op != `OP_NULL);

  // Lowest-index ready entry for issue and lowest-index free entry for dispatch
  always_comb begin
    w_sel_idx  = '0;
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      w_sel_idx  = w_ready[i] ? IDX_W'(i) : w_sel_idx;
      w_free_idx = !r_busy[i] ? IDX_W'(i) : w_free_idx;
    end
  end

  // CDB tag matches for stored entries and for the instruction being dispatched
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_look_j[i] = cdb_lookup(r_qj[i], i_cdb_alu_en, i_cdb_alu_robid, i_cdb_alu_value,
                               i_cdb_lsb_en, i_cdb_lsb_robid, i_cdb_lsb_value);
      w_look_k[i] = cdb_lookup(r_qk[i], i_cdb_alu_en, i_cdb_alu_robid, i_cdb_alu_value,
                               i_cdb_lsb_en, i_cdb_lsb_robid, i_cdb_lsb_value);
    end
    w_disp_look_j  = cdb_lookup(i_disp_qj, i_cdb_alu_en, i_cdb_alu_robid, i_cdb_alu_value,
                                i_cdb_lsb_en, i_cdb_lsb_robid, i_cdb_lsb_value);
    w_disp_look_k  = cdb_lookup(i_disp_qk, i_cdb_alu_en, i_cdb_alu_robid, i_cdb_alu_value,
                                i_cdb_lsb_en, i_cdb_lsb_robid, i_cdb_lsb_value);
    w_disp_qj_busy = i_disp_qj_busy && !w_disp_look_j[32];
    w_disp_qk_busy = i_disp_qk_busy && !w_disp_look_k[32];
    w_disp_vj      = (i_disp_qj_busy && w_disp_look_j[32]) ? w_disp_look_j[31:0] : i_disp_vj;
    w_disp_vk      = (i_disp_qk_busy && w_disp_look_k[32]) ? w_disp_look_k[31:0] : i_disp_vk;
  end

  // Entry storage, wake-up, issue and dispatch; rdy low freezes everything
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy      <= '0;
      r_qj_busy   <= '0;
      r_qk_busy   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]    <= `OP_NULL;
        r_vj[i]    <= 32'd0;
        r_vk[i]    <= 32'd0;
        r_imm[i]   <= 32'd0;
        r_curpc[i] <= 32'd0;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
        r_robid[i] <= '0;
      end
      r_alu_valid <= 1'b0;
      r_alu_op    <= `OP_NULL;
      r_alu_vj    <= 32'd0;
      r_alu_vk    <= 32'd0;
      r_alu_imm   <= 32'd0;
      r_alu_curpc <= 32'd0;
      r_alu_robid <= '0;
    end else if (i_rdy) begin
      if (i_clear) begin
        r_busy      <= '0;
        r_alu_valid <= 1'b0;
        r_alu_op    <= `OP_NULL;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && r_qj_busy[i] && w_look_j[i][32]) begin
            r_vj[i]      <= w_look_j[i][31:0];
            r_qj_busy[i] <= 1'b0;
          end
          if (r_busy[i] && r_qk_busy[i] && w_look_k[i][32]) begin
            r_vk[i]      <= w_look_k[i][31:0];
            r_qk_busy[i] <= 1'b0;
          end
        end
        if (w_sel_valid) begin
          r_alu_valid       <= 1'b1;
          r_alu_op          <= r_op[w_sel_idx];
          r_alu_vj          <= r_vj[w_sel_idx];
          r_alu_vk          <= r_vk[w_sel_idx];
          r_alu_imm         <= r_imm[w_sel_idx];
          r_alu_curpc       <= r_curpc[w_sel_idx];
          r_alu_robid       <= r_robid[w_sel_idx];
          r_busy[w_sel_idx] <= 1'b0;
        end else begin
          r_alu_valid <= 1'b0;
          r_alu_op    <= `OP_NULL;
        end
        if (w_disp_fire) begin
          r_busy[w_free_idx]    <= 1'b1;
          r_op[w_free_idx]      <= i_disp_op;
          r_vj[w_free_idx]      <= w_disp_vj;
          r_vk[w_free_idx]      <= w_disp_vk;
          r_qj_busy[w_free_idx] <= w_disp_qj_busy;
          r_qk_busy[w_free_idx] <= w_disp_qk_busy;
          r_qj[w_free_idx]      <= i_disp_qj;
          r_qk[w_free_idx]      <= i_disp_qk;
          r_imm[w_free_idx]     <= i_disp_imm;
          r_curpc[w_free_idx]   <= i_disp_curpc;
          r_robid[w_free_idx]   <= i_disp_robid;
        end
      end
    end
  end

  assign o_rs_full   = w_full;
  assign o_alu_valid = r_alu_valid;
  assign o_alu_op    = r_alu_op;
  assign o_alu_vj    = r_alu_vj;
  assign o_alu_vk    = r_alu_vk;
  assign o_alu_imm   = r_alu_imm;
  assign o_alu_curpc = r_alu_curpc;
  assign o_alu_robid = r_alu_robid;

endmodule
